fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word fetches to instruction memory over a request/grant/response handshake that may have variable latency.
- Buffers returned instructions with their PCs in a FIFO and delivers them to decode over valid/ready.
- Handles branch/jump redirect (flush) and halt. Decode stall is expressed by deasserting out_ready.

Parameters:
- PC_WIDTH, 9, fetch address width in bytes; wraps modulo 2^PC_WIDTH.
- INSTRUCTION_WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; state is reset while rst==0.
- redirect  in  1  flush and restart fetch; driven by the EX-stage PCSel.
- redirect_pc  in  PC_WIDTH  new fetch address; valid while redirect==1.
- halt  in  1  stop issuing new fetches.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_gnt  in  1  request accepted this cycle; ignored unless imem_req==1.
- imem_rvalid  in  1  response data valid; responses return in request order.
- imem_rdata  in  INSTRUCTION_WIDTH  fetched instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head entry (0 = stall).
- out_pc  out  PC_WIDTH  PC of the head entry.
- out_instr  out  INSTRUCTION_WIDTH  instruction of the head entry.
- count  out  clog2(DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (rst==0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RUN.
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, count=0.
- States:
  - RUN: fetching.
  - HALTED: no new requests.
  - RUN->HALTED when halt==1 at a clock edge. HALTED->RUN only on redirect==1. Otherwise HALTED holds until reset.
- imem_req is asserted combinationally when all of the following hold:
  - state==RUN, halt==0 and redirect==0;
  - count + outstanding < DEPTH, which guarantees a slot for every response;
  - outstanding < MAX_OUTSTANDING.
- imem_addr=fetch_pc.
- On imem_req and imem_gnt: fetch_pc += 4 (wrap mod 2^PC_WIDTH) and outstanding increments.
- An ungranted request may be withdrawn, or its address changed, on redirect or halt.
- On imem_rvalid: outstanding decrements.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise {pc, instr} is pushed. The pc is tracked in a PC tag FIFO written at grant time.
- Pop occurs on out_valid and out_ready. out_pc/out_instr show the head entry; both are 0 when empty.
- count updates on push and pop; a simultaneous push and pop leaves count unchanged.
- Redirect, evaluated at the clock edge:
  - FIFO is cleared and fetch_pc=redirect_pc.
  - discard = outstanding_next, the number of in-flight requests after this cycle's grant and response are accounted for.
  - A response in the same cycle is dropped, and any pop in the same cycle is ignored.
  - Redirect has priority over halt.
- Response latency: the first out_valid is 1 cycle after the imem_rvalid that carries a non-discarded response.
- Full FIFO: no request is issued; out_valid stays 1.
- Reset mid-transaction: all counters clear. Memory responses arriving after reset deassertion for requests issued before reset are system-illegal and not handled.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN
- Defined: when the FIFO is empty and a non-discarded imem_rvalid arrives, out_valid/out_pc/out_instr present it combinationally in the same cycle. If out_ready==1 it is consumed without a push; otherwise it is pushed.
- Undefined: every response goes through the FIFO, with the 1-cycle latency described under Behaviour.

Decomposition:
- Shared pipeline buffer package:
  - typedef fetch_entry_t {pc[PC_WIDTH], instr[INSTRUCTION_WIDTH]};
  - enum fetch_state_t {RUN, HALTED};
  - constant NOP_INSTR=32'h00000013.
- Sub-module fetch_fifo: synchronous FIFO with async active-low reset, clear input, and push/pop/count. It is instantiated twice: once for the entry queue and once for the PC tags of in-flight requests.

Test Plan:
- Reset then release, memory grants every cycle with 1-cycle rvalid, out_ready=1 -> out_pc sequence 0x000, 0x004, 0x008...; first out_valid 2 cycles after the first grant.
- out_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0; count=4; with out_ready=1 the entries pop in order 0x000..0x00C.
- Two requests in flight (0x010, 0x014), then redirect with redirect_pc=0x100 -> both responses are dropped, the next pushed entry has pc=0x100, and count=0 immediately after the redirect.
- Redirect in the same cycle as imem_rvalid and a pop -> the response is dropped, the FIFO is empty next cycle, and no out_valid occurs until the response for 0x100.
- halt=1 at pc 0x020 -> no further grants, in-flight responses are still delivered, and the state stays HALTED; a redirect to 0x040 resumes fetching at 0x040.
- fetch_pc=0x1FC granted -> the next imem_addr is 0x000. With FETCH_QUEUE_BYPASS_EN defined and the FIFO empty, out_valid is seen in the same cycle as imem_rvalid.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int unsigned PC_WIDTH          = 9;
    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned DEPTH             = 4;
    localparam int unsigned MAX_OUTSTANDING   = 2;
    localparam int unsigned RESET_PC          = 0;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with async active-low reset, synchronous clear and
// a combinational head view. Push on full and pop on empty are ignored.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset; the head is only meaningful while count != 0
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues memory requests and
// buffers responses for decode. Define FETCH_QUEUE_BYPASS_EN for empty-queue bypass.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    input  logic                         halt,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_instr,
    output logic [CNT_W-1:0]             count
);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [OUT_W-1:0]    outstanding;
    logic [OUT_W-1:0]    outstanding_nxt;
    logic [OUT_W-1:0]    discard;
    logic [PC_WIDTH-1:0] tag_head;
    fetch_entry_t        rsp_entry;
    fetch_entry_t        head_entry;
    logic                grant;
    logic                slot_free;
    logic                rsp_keep;
    logic                entry_empty;
    logic                entry_push;
    logic                entry_pop;

    assign imem_addr       = fetch_pc;
    assign grant           = imem_req && imem_gnt;
    assign slot_free       = (32'(count) + 32'(outstanding)) < DEPTH;
    assign outstanding_nxt = outstanding + OUT_W'(grant) - OUT_W'(imem_rvalid);
    assign rsp_keep        = imem_rvalid && (discard == '0) && !redirect;
    assign entry_empty     = (count == '0);
    assign rsp_entry       = '{pc: tag_head, instr: imem_rdata};

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    // next state and request generation; redirect outranks halt
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            RUN: begin
                if (redirect)  state_nxt = RUN;
                else if (halt) state_nxt = HALTED;
                if (rst && !halt && !redirect && slot_free &&
                    (outstanding < OUT_W'(MAX_OUTSTANDING)))
                    imem_req = 1'b1;
            end
            HALTED: begin
                if (redirect) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // fetch PC and count of in-flight responses to drop after a redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= PC_WIDTH'(RESET_PC);
            discard  <= '0;
        end else begin
            if (redirect)   fetch_pc <= redirect_pc;
            else if (grant) fetch_pc <= fetch_pc + PC_WIDTH'(4);

            if (redirect)
                discard <= outstanding_nxt;
            else if (imem_rvalid && (discard != '0))
                discard <= discard - OUT_W'(1);
        end
    end

    // head presentation, optional bypass, push/pop control
    always_comb begin
        out_valid  = !entry_empty;
        out_pc     = entry_empty ? '0 : head_entry.pc;
        out_instr  = entry_empty ? '0 : head_entry.instr;
        entry_push = rsp_keep;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (entry_empty && rsp_keep) begin
            out_valid  = 1'b1;
            out_pc     = tag_head;
            out_instr  = imem_rdata;
            entry_push = !out_ready;
        end
`endif
        entry_pop = !entry_empty && out_ready && !redirect;
    end

    // PCs of granted requests, retired in order as responses return
    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (imem_rvalid),
        .head      (tag_head),
        .count     (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (entry_push),
        .push_data (rsp_entry),
        .pop       (entry_pop),
        .head      (head_entry),
        .count     (count)
    );

endmodule
